serial_to_parallel_converter: RTL and testbench

//   Receive-side counterpart of the parallel_to_serial_converter: deserialises a
//   bit stream into N-bit words. Supports MSB-first and LSB-first ordering.

---
 rtl/serial_to_parallel_converter.sv | 101 ++++++++++
 tb/tb_serial_to_parallel_converter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_converter.sv
// Serial-to-parallel deserialiser with MSB/LSB-first ordering and a valid/ready word output.
// Optional build macro PARITY_CHECK_EN appends one even-parity bit per word and checks it.
package s2p_pkg;
  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } shift_direction_t_;
endpackage

module serial_to_parallel_converter
  import s2p_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic                   i_bit,
  input  shift_direction_t_      direction,
  input  logic                   i_clear,
  input  logic                   o_ready,
  output logic [N-1:0]           o_data,
  output logic                   o_valid,
  output logic                   o_overrun,
  output logic                   o_parity_err,
  output logic [N-1:0]           q,
  output logic [$clog2(N+1)-1:0] count
);

  localparam int CW = $clog2(N+1);
  localparam logic [CW-1:0] N_CNT = CW'(N);
`ifdef PARITY_CHECK_EN
  localparam logic [CW-1:0] LAST_CNT = CW'(N);
`else
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
`endif

  shift_direction_t_ r_dir;
  shift_direction_t_ w_dir;
  logic              w_accept;
  logic              w_is_data;
  logic              w_last;
  logic              w_take;
  logic [N-1:0]      w_shift;
  logic [N-1:0]      w_word;

  // The first bit of a word uses the live direction input; later bits use the latched one.
  assign w_dir     = (count == '0) ? direction : r_dir;
  assign w_accept  = i_valid && !i_clear;
  assign w_is_data = (count < N_CNT);
  assign w_shift   = (w_dir == MSB_FIRST) ? {q[N-2:0], i_bit} : {i_bit, q[N-1:1]};
  assign w_last    = w_accept && (count == LAST_CNT);
  assign w_take    = w_last && (!o_valid || o_ready);

`ifdef PARITY_CHECK_EN
  // The parity bit is not shifted in, so the word is already complete in q.
  assign w_word = q;
`else
  assign w_word = w_shift;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q         <= '0;
      count     <= '0;
      r_dir     <= MSB_FIRST;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= w_last && o_valid && !o_ready;
      if (i_clear) begin
        q     <= '0;
        count <= '0;
      end else if (i_valid) begin
        if (count == '0) r_dir <= direction;
        if (w_is_data) q <= w_shift;
        count <= w_last ? '0 : count + 1'b1;
      end
      if (w_take) begin
        o_data  <= w_word;
        o_valid <= 1'b1;
      end else if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_parity_err <= 1'b0;
    end else if (w_take) begin
      o_parity_err <= ^{q, i_bit};
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel_converter.sv
// Bench for serial_to_parallel_converter: directed scenarios then random traffic,
// every cycle compared against an arithmetic model of the receiver.
module tb_serial_to_parallel_converter;
  import s2p_pkg::*;

  localparam int N  = 8;
  localparam int CW = $clog2(N+1);
`ifdef PARITY_CHECK_EN
  localparam int L   = N + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int L   = N;
  localparam bit PAR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid, i_bit, i_clear, o_ready;
  shift_direction_t_ direction;
  logic [N-1:0]      o_data, q;
  logic              o_valid, o_overrun, o_parity_err;
  logic [CW-1:0]     count;

  serial_to_parallel_converter #(.N(N)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_bit(i_bit),
    .direction(direction), .i_clear(i_clear), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .o_overrun(o_overrun),
    .o_parity_err(o_parity_err), .q(q), .count(count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  int                m_q, m_cnt, m_data, m_valid, m_ovr, m_perr;
  shift_direction_t_ m_dir;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_cnt = 0; m_data = 0; m_valid = 0; m_ovr = 0; m_perr = 0;
    m_dir = MSB_FIRST;
  endtask

  task automatic check_all();
    chk("o_valid", int'(o_valid), m_valid);
    chk("o_data", int'(o_data), m_data);
    chk("o_overrun", int'(o_overrun), m_ovr);
    chk("o_parity_err", int'(o_parity_err), m_perr);
    chk("count", int'(count), m_cnt);
    chk("q", int'(q), m_q);
  endtask

  task automatic step(input logic v, input logic b, input shift_direction_t_ d,
                      input logic clr, input logic rdy);
    bit done;
    int word, pe;
    i_valid = v; i_bit = b; direction = d; i_clear = clr; o_ready = rdy;
    done = 0; word = 0; pe = 0;
    m_ovr = 0;
    if (clr) begin
      m_q = 0; m_cnt = 0;
    end else if (v) begin
      if (m_cnt == 0) m_dir = d;
      if (m_cnt < N)
        m_q = (m_dir == MSB_FIRST) ? ((m_q * 2 + int'(b)) % (1 << N))
                                   : (m_q / 2 + int'(b) * (1 << (N - 1)));
      if (m_cnt == L - 1) begin
        done  = 1;
        word  = m_q;
        pe    = PAR ? (($countones(m_q) + int'(b)) % 2) : 0;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    if (done) begin
      if (m_valid == 0 || rdy) begin
        m_data = word; m_valid = 1; m_perr = pe;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid != 0 && rdy) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic even_par(input logic [N-1:0] w);
    return ^w;
  endfunction

  task automatic send_word(input logic [N-1:0] w, input shift_direction_t_ d,
                           input int gap, input logic rdy, input logic pbit);
    for (int i = 0; i < N; i++) begin
      step(1'b1, (d == MSB_FIRST) ? w[N-1-i] : w[i], d, 1'b0, rdy);
      if (i < N - 1) repeat (gap) step(1'b0, 1'b0, d, 1'b0, rdy);
    end
    if (PAR) step(1'b1, pbit, d, 1'b0, rdy);
  endtask

  initial begin
    logic [N-1:0] w;
    rst = 1'b0; i_valid = 1'b0; i_bit = 1'b0; i_clear = 1'b0; o_ready = 1'b0;
    direction = MSB_FIRST;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // 1: MSB first 0xAA back to back
    send_word(8'hAA, MSB_FIRST, 0, 1'b1, 1'b0);
    chk("t1_data", int'(o_data), 8'hAA);
    chk("t1_valid", int'(o_valid), 1);
    chk("t1_count", int'(count), 0);
    step(1'b0, 1'b0, MSB_FIRST, 1'b0, 1'b1);

    // 2: LSB first 0xA5 with 2-cycle gaps
    send_word(8'hA5, LSB_FIRST, 2, 1'b1, even_par(8'hA5));
    chk("t2_data", int'(o_data), 8'hA5);
    step(1'b0, 1'b0, MSB_FIRST, 1'b0, 1'b1);

    // 3: overrun with consumer stalled
    send_word(8'h3C, MSB_FIRST, 0, 1'b0, even_par(8'h3C));
    send_word(8'hFF, MSB_FIRST, 0, 1'b0, even_par(8'hFF));
    chk("t3_overrun", int'(o_overrun), 1);
    chk("t3_data", int'(o_data), 8'h3C);
    step(1'b0, 1'b0, MSB_FIRST, 1'b0, 1'b0);
    chk("t3_ovr_pulse", int'(o_overrun), 0);
    step(1'b0, 1'b0, MSB_FIRST, 1'b0, 1'b1);
    chk("t3_drop", int'(o_valid), 0);

    // 4: async reset mid-word
    step(1'b1, 1'b1, MSB_FIRST, 1'b0, 1'b1);
    step(1'b1, 1'b0, MSB_FIRST, 1'b0, 1'b1);
    step(1'b1, 1'b1, MSB_FIRST, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rst = 1'b1;
    send_word(8'h81, MSB_FIRST, 0, 1'b1, even_par(8'h81));
    chk("t4_data", int'(o_data), 8'h81);
    step(1'b0, 1'b0, MSB_FIRST, 1'b0, 1'b1);

    // 5: direction change mid-word is ignored, then clear aborts a partial word
    w = 8'hC3;
    for (int i = 0; i < N; i++)
      step(1'b1, w[N-1-i], (i < 4) ? MSB_FIRST : LSB_FIRST, 1'b0, 1'b1);
    if (PAR) step(1'b1, even_par(w), LSB_FIRST, 1'b0, 1'b1);
    chk("t5_data", int'(o_data), 8'hC3);
    step(1'b0, 1'b0, MSB_FIRST, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, MSB_FIRST, 1'b0, 1'b1);
    step(1'b1, 1'b1, MSB_FIRST, 1'b1, 1'b1);
    chk("t5_clr_count", int'(count), 0);
    chk("t5_clr_valid", int'(o_valid), 0);

`ifdef PARITY_CHECK_EN
    // 6: parity check
    send_word(8'hAA, MSB_FIRST, 0, 1'b1, 1'b0);
    chk("t6_perr_ok", int'(o_parity_err), 0);
    step(1'b0, 1'b0, MSB_FIRST, 1'b0, 1'b1);
    send_word(8'hAB, MSB_FIRST, 0, 1'b1, 1'b0);
    chk("t6_perr_bad", int'(o_parity_err), 1);
    chk("t6_valid", int'(o_valid), 1);
    step(1'b0, 1'b0, MSB_FIRST, 1'b0, 1'b1);
`endif

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 1) != 0) ? LSB_FIRST : MSB_FIRST,
           ($urandom_range(0, 40) == 0), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
